// File: rtl/axis_i2c_arb_pkg.sv
// Shared definitions for the I2C command arbiter: FSM encoding, legacy command
// word field offsets and the default read-timeout response value.
package axis_i2c_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ISSUE    = 2'd1,
        ST_WAIT_INT = 2'd2,
        ST_RESP     = 2'd3
    } arb_state_e;

    localparam int unsigned CMD_W         = 32;
    localparam int unsigned CMD_RDVAL_BIT = 31;
    localparam int unsigned CMD_RDSZ_BIT  = 28;
    localparam int unsigned CMD_WRSZ_BIT  = 26;
    localparam int unsigned CMD_DEVNO_BIT = 24;

    localparam logic [CMD_W-1:0] DEFAULT_ERROR_VALUE = 32'hbaadbeef;

endpackage

// File: rtl/i2c_rr_pick.sv
// Combinational round-robin selector: first requester at or after last_i+1,
// wrapping modulo REQ_COUNT.
module i2c_rr_pick
    import axis_i2c_arb_pkg::*;
#(
    parameter  int unsigned REQ_COUNT = 4,
    localparam int unsigned GW        = $clog2(REQ_COUNT)
) (
    input  logic [REQ_COUNT-1:0] req_i,
    input  logic [GW-1:0]        last_i,
    output logic                 any_o,
    output logic [GW-1:0]        grant_o
);

    localparam int unsigned   SW  = GW + 1;
    localparam logic [SW-1:0] N_S = SW'(REQ_COUNT);

    logic [SW-1:0] cand;

    // Scan from the farthest offset down so the nearest pending requester wins.
    always_comb begin
        any_o   = 1'b0;
        grant_o = last_i;
        cand    = '0;
        for (int k = REQ_COUNT; k >= 1; k--) begin
            cand = {1'b0, last_i} + SW'(k);
            if (cand >= N_S) begin
                cand = cand - N_S;
            end
            if (req_i[cand[GW-1:0]]) begin
                any_o   = 1'b1;
                grant_o = cand[GW-1:0];
            end
        end
    end

endmodule

// File: rtl/axis_i2c_cmd_arbiter.sv
// Round-robin arbiter sharing one legacy I2C command engine between several
// AXI-Stream requesters; a grant is held until write acceptance or read response.
module axis_i2c_cmd_arbiter
    import axis_i2c_arb_pkg::*;
#(
    parameter int unsigned      REQ_COUNT    = 4,
    parameter int unsigned      TIMEOUT_BITS = 20,
    parameter logic [CMD_W-1:0] ERROR_VALUE  = DEFAULT_ERROR_VALUE
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [REQ_COUNT-1:0]       s_cmd_valid,
    input  logic [CMD_W*REQ_COUNT-1:0] s_cmd_data,
    output logic [REQ_COUNT-1:0]       s_cmd_ready,
    output logic [REQ_COUNT-1:0]       m_rsp_valid,
    output logic [CMD_W-1:0]           m_rsp_data,
    input  logic [REQ_COUNT-1:0]       m_rsp_ready,
    output logic                       m_cmd_valid,
    output logic [CMD_W-1:0]           m_cmd_data,
    input  logic                       m_cmd_ready,
    input  logic [CMD_W-1:0]           s_rb_data,
    input  logic                       s_int_valid,
    output logic                       s_int_ready,
    output logic [15:0]                stat_timeouts
);

    localparam int unsigned GW = $clog2(REQ_COUNT);

    arb_state_e              state_q, state_d;
    logic [GW-1:0]           grant_q, grant_d;
    logic [GW-1:0]           last_q, last_d;
    logic                    cmd_valid_q, cmd_valid_d;
    logic [REQ_COUNT-1:0]    rsp_valid_q, rsp_valid_d;
    logic [CMD_W-1:0]        rsp_data_q, rsp_data_d;
    logic [TIMEOUT_BITS-1:0] tmo_q, tmo_d;
    logic [15:0]             stat_q, stat_d;

    logic [TIMEOUT_BITS-1:0] tmo_inc;
    logic [REQ_COUNT-1:0]    grant_oh;
    logic [CMD_W-1:0]        cmd_word;
    logic [REQ_COUNT-1:0]    cmd_ready_c;
    logic                    int_ready_c;
    logic                    pick_any;
    logic [GW-1:0]           pick_idx;

    i2c_rr_pick #(
        .REQ_COUNT (REQ_COUNT)
    ) u_pick (
        .req_i   (s_cmd_valid),
        .last_i  (last_q),
        .any_o   (pick_any),
        .grant_o (pick_idx)
    );

    assign grant_oh = REQ_COUNT'(1) << grant_q;
    assign tmo_inc  = tmo_q + TIMEOUT_BITS'(1);

    // Command word of the granted requester.
    always_comb begin
        cmd_word = '0;
        for (int i = 0; i < REQ_COUNT; i++) begin
            if (grant_q == GW'(i)) begin
                cmd_word = s_cmd_data[CMD_W*i +: CMD_W];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        last_d      = last_q;
        cmd_valid_d = cmd_valid_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        tmo_d       = tmo_q;
        stat_d      = stat_q;
        cmd_ready_c = '0;
        int_ready_c = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                int_ready_c = 1'b1;
                if (pick_any) begin
                    grant_d     = pick_idx;
                    last_d      = pick_idx;
                    cmd_valid_d = 1'b1;
                    state_d     = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                cmd_ready_c = grant_oh & {REQ_COUNT{m_cmd_ready}};
                if (m_cmd_ready) begin
                    cmd_valid_d = 1'b0;
                    if (cmd_word[CMD_RDVAL_BIT]) begin
                        tmo_d   = '0;
                        state_d = ST_WAIT_INT;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_WAIT_INT: begin
                int_ready_c = 1'b1;
                // Interrupt has priority over a timeout in the same cycle.
                if (s_int_valid) begin
                    rsp_data_d  = s_rb_data;
                    rsp_valid_d = grant_oh;
                    state_d     = ST_RESP;
                end else begin
                    tmo_d = tmo_inc;
                    if (&tmo_inc) begin
                        rsp_data_d  = ERROR_VALUE;
                        rsp_valid_d = grant_oh;
                        state_d     = ST_RESP;
                        if (stat_q != 16'hffff) begin
                            stat_d = stat_q + 16'd1;
                        end
                    end
                end
            end
            ST_RESP: begin
                if (|(m_rsp_ready & grant_oh)) begin
                    rsp_valid_d = '0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            grant_q     <= '0;
            last_q      <= GW'(REQ_COUNT - 1);
            cmd_valid_q <= 1'b0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            tmo_q       <= '0;
            stat_q      <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            last_q      <= last_d;
            cmd_valid_q <= cmd_valid_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            tmo_q       <= tmo_d;
            stat_q      <= stat_d;
        end
    end

    assign m_cmd_valid   = cmd_valid_q;
    assign m_cmd_data    = cmd_word;
    assign s_cmd_ready   = cmd_ready_c;
    assign m_rsp_valid   = rsp_valid_q;
    assign m_rsp_data    = rsp_data_q;
    assign s_int_ready   = int_ready_c;
    assign stat_timeouts = stat_q;

endmodule

// File: tb/tb_axis_i2c_cmd_arbiter.sv
// Self-checking bench for axis_i2c_cmd_arbiter: directed transaction table,
// reset/round-robin sequences and randomized traffic against a reference model.
module tb_axis_i2c_cmd_arbiter;

    localparam int N  = 4;
    localparam int TB = 4;
    localparam int TMO_CYC = (1 << TB) - 1;
    localparam logic [31:0] ERRV = 32'hbaadbeef;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [N-1:0]  s_cmd_valid = '0;
    logic [32*N-1:0] s_cmd_data = '0;
    logic [N-1:0]  s_cmd_ready;
    logic [N-1:0]  m_rsp_valid;
    logic [31:0]   m_rsp_data;
    logic [N-1:0]  m_rsp_ready = '0;
    logic          m_cmd_valid;
    logic [31:0]   m_cmd_data;
    logic          m_cmd_ready = 1'b0;
    logic [31:0]   s_rb_data = '0;
    logic          s_int_valid = 1'b0;
    logic          s_int_ready;
    logic [15:0]   stat_timeouts;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    axis_i2c_cmd_arbiter #(
        .REQ_COUNT    (N),
        .TIMEOUT_BITS (TB),
        .ERROR_VALUE  (ERRV)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .s_cmd_valid   (s_cmd_valid),
        .s_cmd_data    (s_cmd_data),
        .s_cmd_ready   (s_cmd_ready),
        .m_rsp_valid   (m_rsp_valid),
        .m_rsp_data    (m_rsp_data),
        .m_rsp_ready   (m_rsp_ready),
        .m_cmd_valid   (m_cmd_valid),
        .m_cmd_data    (m_cmd_data),
        .m_cmd_ready   (m_cmd_ready),
        .s_rb_data     (s_rb_data),
        .s_int_valid   (s_int_valid),
        .s_int_ready   (s_int_ready),
        .stat_timeouts (stat_timeouts)
    );

    typedef struct {
        int          idx;
        logic [31:0] word;
        int          rdy_dly;
        int          int_dly;
        logic [31:0] rb;
        bit          exp_rsp;
        logic [31:0] exp_data;
        int          exp_lat;
        int          exp_stat;
    } vec_t;

    vec_t tbl[7];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive one granted transaction from arbitration through response handshake.
    task automatic do_txn(input int idx, input logic [31:0] word, input int rdy_dly,
                          input int int_dly, input logic [31:0] rb, input bit exp_rsp,
                          input logic [31:0] exp_data, input int exp_lat, input int rsp_dly);
        logic [N-1:0] oh;
        int n;
        oh = N'(1) << idx;
        tick();
        chk("cmd_valid", 32'(m_cmd_valid), 32'd1);
        chk("cmd_data", m_cmd_data, word);
        chk("cmd_ready_wait", 32'(s_cmd_ready), 32'd0);
        repeat (rdy_dly) tick();
        m_cmd_ready = 1'b1;
        #1;
        chk("cmd_ready", 32'(s_cmd_ready), 32'(oh));
        tick();
        m_cmd_ready = 1'b0;
        s_cmd_valid[idx] = 1'b0;
        chk("cmd_valid_drop", 32'(m_cmd_valid), 32'd0);
        if (!exp_rsp) begin
            chk("write_no_rsp", 32'(m_rsp_valid), 32'd0);
            chk("write_idle_int_ready", 32'(s_int_ready), 32'd1);
            return;
        end
        n = 0;
        while (n < 40) begin
            if (n + 1 == int_dly) begin
                s_int_valid = 1'b1;
                s_rb_data   = rb;
            end
            tick();
            s_int_valid = 1'b0;
            s_rb_data   = $urandom;
            n++;
            if (m_rsp_valid != '0) break;
        end
        chk("rsp_latency", 32'(n), 32'(exp_lat));
        chk("rsp_valid", 32'(m_rsp_valid), 32'(oh));
        chk("rsp_data", m_rsp_data, exp_data);
        repeat (rsp_dly) begin
            tick();
            chk("rsp_hold_valid", 32'(m_rsp_valid), 32'(oh));
            chk("rsp_hold_data", m_rsp_data, exp_data);
            chk("rsp_int_ready", 32'(s_int_ready), 32'd0);
        end
        m_rsp_ready = oh;
        tick();
        m_rsp_ready = '0;
        chk("rsp_done", 32'(m_rsp_valid), 32'd0);
        chk("rsp_idle_int_ready", 32'(s_int_ready), 32'd1);
    endtask

    // Wait (bounded) for a command offer and check which requester owns it.
    task automatic expect_grant(input int exp_idx, input string name);
        int w;
        logic [N-1:0] oh;
        oh = N'(1) << exp_idx;
        w = 0;
        while (s_cmd_ready == '0 && w < 6) begin
            tick();
            w++;
        end
        chk(name, 32'(s_cmd_ready), 32'(oh));
        chk({name, "_data"}, m_cmd_data, s_cmd_data[32*exp_idx +: 32]);
        tick();
    endtask

    // Winner is the pending requester nearest after the last one served.
    function automatic int model_pick(input logic [N-1:0] pend, input int last);
        int best, bestd, d;
        best  = -1;
        bestd = N + 1;
        for (int i = 0; i < N; i++) begin
            d = (i - last - 1 + 2 * N) % N;
            if (pend[i] && d < bestd) begin
                bestd = d;
                best  = i;
            end
        end
        return best;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [N-1:0]  pend;
        logic [31:0]   words[N];
        int            last, best, tmo_model, d, lat;
        logic [31:0]   rb, edata;
        bit            is_rd;

        tbl[0] = '{0, 32'h0500_1234, 3, 0,  32'h0,         1'b0, 32'h0,         0,  0};
        tbl[1] = '{2, 32'h9100_00AB, 1, 2,  32'hDEAD_0042, 1'b1, 32'hDEAD_0042, 2,  0};
        tbl[2] = '{3, 32'h8000_0011, 0, 0,  32'h1111_2222, 1'b1, ERRV,          15, 1};
        tbl[3] = '{1, 32'h9200_0033, 2, 15, 32'hCAFE_F00D, 1'b1, 32'hCAFE_F00D, 15, 1};
        tbl[4] = '{0, 32'h8400_0001, 0, 1,  32'h0000_00A5, 1'b1, 32'h0000_00A5, 1,  1};
        tbl[5] = '{2, 32'h0700_5555, 0, 0,  32'h0,         1'b0, 32'h0,         0,  1};
        tbl[6] = '{1, 32'h8000_0002, 1, 14, 32'h1234_5678, 1'b1, 32'h1234_5678, 14, 1};

        #2 rst_n = 1'b0;
        #1;
        chk("rst_cmd_valid", 32'(m_cmd_valid), 32'd0);
        chk("rst_rsp_valid", 32'(m_rsp_valid), 32'd0);
        chk("rst_rsp_data", m_rsp_data, 32'd0);
        chk("rst_stat", 32'(stat_timeouts), 32'd0);
        chk("rst_int_ready", 32'(s_int_ready), 32'd1);
        chk("rst_cmd_ready", 32'(s_cmd_ready), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Stray interrupt while idle is acknowledged and dropped.
        s_int_valid = 1'b1;
        s_rb_data   = 32'h5555_AAAA;
        #1;
        chk("stray_int_ready", 32'(s_int_ready), 32'd1);
        tick();
        s_int_valid = 1'b0;
        chk("stray_no_rsp", 32'(m_rsp_valid), 32'd0);
        chk("stray_no_cmd", 32'(m_cmd_valid), 32'd0);
        tick();
        chk("stray_no_rsp2", 32'(m_rsp_valid), 32'd0);

        for (int t = 0; t < 7; t++) begin
            s_cmd_data[32*tbl[t].idx +: 32] = tbl[t].word;
            s_cmd_valid[tbl[t].idx] = 1'b1;
            do_txn(tbl[t].idx, tbl[t].word, tbl[t].rdy_dly, tbl[t].int_dly, tbl[t].rb,
                   tbl[t].exp_rsp, tbl[t].exp_data, tbl[t].exp_lat, 2);
            chk("tbl_stat", 32'(stat_timeouts), 32'(tbl[t].exp_stat));
        end

        // Reset in the middle of a read abandons it immediately.
        s_cmd_data[32*2 +: 32] = 32'h9300_0077;
        s_cmd_valid[2] = 1'b1;
        tick();
        m_cmd_ready = 1'b1;
        tick();
        m_cmd_ready = 1'b0;
        s_cmd_valid = '0;
        repeat (3) tick();
        chk("wait_int_ready", 32'(s_int_ready), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_cmd_valid", 32'(m_cmd_valid), 32'd0);
        chk("midrst_rsp_valid", 32'(m_rsp_valid), 32'd0);
        chk("midrst_rsp_data", m_rsp_data, 32'd0);
        chk("midrst_stat", 32'(stat_timeouts), 32'd0);
        chk("midrst_int_ready", 32'(s_int_ready), 32'd1);
        tick();
        tick();
        rst_n = 1'b1;

        // All four hold writes: strict rotation starting at requester 0.
        for (int i = 0; i < N; i++) s_cmd_data[32*i +: 32] = 32'h0100_0000 | 32'(i);
        s_cmd_valid = '1;
        m_cmd_ready = 1'b1;
        for (int k = 0; k < 8; k++) expect_grant(k % N, "rr_order");
        s_cmd_valid = 4'b0010;
        expect_grant(1, "rr_single1");
        s_cmd_valid = 4'b1010;
        expect_grant(3, "rr_skip_to3");
        s_cmd_valid = 4'b0010;
        expect_grant(1, "rr_then1");
        s_cmd_valid = '0;
        m_cmd_ready = 1'b0;
        tick();
        chk("rr_idle", 32'(m_cmd_valid), 32'd0);

        // Randomized traffic against the reference model.
        last      = 1;
        tmo_model = 0;
        pend      = '0;
        for (int t = 0; t < 60; t++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && ($urandom_range(0, 1) == 1)) begin
                    pend[i]     = 1'b1;
                    words[i]    = $urandom;
                    words[i][31] = 1'($urandom_range(0, 1));
                    s_cmd_data[32*i +: 32] = words[i];
                    s_cmd_valid[i] = 1'b1;
                end
            end
            if (pend == '0) begin
                best           = $urandom_range(0, N - 1);
                pend[best]     = 1'b1;
                words[best]    = $urandom;
                s_cmd_data[32*best +: 32] = words[best];
                s_cmd_valid[best] = 1'b1;
            end
            best  = model_pick(pend, last);
            is_rd = words[best][31];
            d     = $urandom_range(1, 18);
            rb    = $urandom;
            edata = (d <= TMO_CYC) ? rb : ERRV;
            lat   = (d <= TMO_CYC) ? d : TMO_CYC;
            if (is_rd && d > TMO_CYC && tmo_model < 65535) tmo_model++;
            do_txn(best, words[best], $urandom_range(0, 3), d, rb, is_rd, edata, lat,
                   $urandom_range(0, 3));
            pend[best] = 1'b0;
            last       = best;
            chk("rand_stat", 32'(stat_timeouts), 32'(tmo_model));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
